// File: rtl/alu_ctrl_pkg.sv
// Shared types for the sequenced ALU controller: opcode and controller FSM state.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    OpAdd = 2'd0,
    OpSub = 2'd1,
    OpCmp = 2'd2,
    OpInc = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_ctrl_alu.sv
// Combinational adder/subtractor: y = a + (s ? ~b : b) + s, with carry out of the top bit.
module alu_seq_ctrl_alu #(
  parameter int unsigned Bits = 8
) (
  input  logic [Bits-1:0] a_i,
  input  logic [Bits-1:0] b_i,
  input  logic            s_i,
  output logic [Bits-1:0] y_o,
  output logic            c_o
);

  logic [Bits-1:0] b_eff;
  logic [Bits:0]   sum;

  always_comb begin
    b_eff = s_i ? ~b_i : b_i;
    sum   = {1'b0, a_i} + {1'b0, b_eff} + {{Bits{1'b0}}, s_i};
    y_o   = sum[Bits-1:0];
    c_o   = sum[Bits];
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Three-state controller that captures one operation, runs it through the ALU and
// holds the registered result and flags until the consumer takes it.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [BITS-1:0] req_a,
  input  logic [BITS-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [BITS-1:0] rsp_data,
  output logic            c_flag,
  output logic            z_flag,
  output logic            busy
);

  state_t          state_q, state_d;
  op_t             op_q, op_d;
  logic [BITS-1:0] a_q, a_d;
  logic [BITS-1:0] b_q, b_d;
  logic [BITS-1:0] rsp_data_q, rsp_data_d;
  logic            c_q, c_d;
  logic            z_q, z_d;

  logic [BITS-1:0] alu_b;
  logic            alu_s;
  logic [BITS-1:0] alu_y;
  logic            alu_c;

  always_comb begin
    alu_b = (op_q == OpInc) ? BITS'(1) : b_q;
    alu_s = (op_q == OpSub) || (op_q == OpCmp);
  end

  alu_seq_ctrl_alu #(
    .Bits (BITS)
  ) u_alu (
    .a_i (a_q),
    .b_i (alu_b),
    .s_i (alu_s),
    .y_o (alu_y),
    .c_o (alu_c)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    c_d        = c_q;
    z_d        = z_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d    = op_t'(req_op);
          a_d     = req_a;
          b_d     = req_b;
          state_d = StExec;
        end
      end
      StExec: begin
        // CMP only updates flags; its data result is the untouched a operand.
        rsp_data_d = (op_q == OpCmp) ? a_q : alu_y;
        c_d        = alu_c;
        z_d        = (alu_y == '0);
        state_d    = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= OpAdd;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      c_q        <= 1'b0;
      z_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      c_q        <= c_d;
      z_q        <= z_d;
    end
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
    busy      = (state_q != StIdle);
    rsp_data  = rsp_data_q;
    c_flag    = c_q;
    z_flag    = z_q;
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: expected results are queued at acceptance and
// compared when the response appears.
module tb_alu_seq_ctrl;

  localparam int unsigned BITS = 8;

  typedef struct {
    logic [BITS-1:0] data;
    logic            c;
    logic            z;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [BITS-1:0] req_a;
  logic [BITS-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [BITS-1:0] rsp_data;
  logic            c_flag;
  logic            z_flag;
  logic            busy;

  int   total;
  int   bad;
  exp_t sb_q[$];

  alu_seq_ctrl #(
    .BITS (BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .c_flag    (c_flag),
    .z_flag    (z_flag),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] op, input logic [BITS-1:0] a,
                                 input logic [BITS-1:0] b);
    exp_t        e;
    logic [BITS:0] s;
    case (op)
      2'd0:    s = {1'b0, a} + {1'b0, b};
      2'd1,
      2'd2:    s = {1'b0, a} + {1'b0, ~b} + 9'd1;
      default: s = {1'b0, a} + 9'd1;
    endcase
    e.data = (op == 2'd2) ? a : s[BITS-1:0];
    e.c    = s[BITS];
    e.z    = (s[BITS-1:0] == '0);
    return e;
  endfunction

  // Present a request at a negedge, wait for acceptance, then check the EXEC->RESP latency.
  task automatic send(input string name, input logic [1:0] op, input logic [BITS-1:0] a,
                      input logic [BITS-1:0] b, input bit keep);
    int waited = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL %s accept: req_ready=%0b required=1", name, req_ready);
    end
    @(posedge clk);
    if (keep) sb_q.push_back(model(op, a, b));
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s exec: rsp_valid=%0b busy=%0b required 0 1", name, rsp_valid, busy);
    end
  endtask

  task automatic collect(input string name);
    int   waited = 0;
    exp_t e;
    while (rsp_valid !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (rsp_valid !== 1'b1 || sb_q.size() == 0) begin
      bad++;
      $display("FAIL %s rsp: rsp_valid=%0b queued=%0d required valid with entry", name,
               rsp_valid, sb_q.size());
      return;
    end
    e = sb_q.pop_front();
    if (rsp_data !== e.data || c_flag !== e.c || z_flag !== e.z) begin
      bad++;
      $display("FAIL %s data: got %h c=%0b z=%0b required %h c=%0b z=%0b", name, rsp_data,
               c_flag, z_flag, e.data, e.c, e.z);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== '0 || c_flag !== 1'b0 ||
        z_flag !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: rdy=%0b vld=%0b data=%h c=%0b z=%0b busy=%0b required 1 0 00 0 0 0",
               req_ready, rsp_valid, rsp_data, c_flag, z_flag, busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ops();
    send("add_f0_10", 2'd0, 8'hF0, 8'h10, 1'b1);
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL add_latency: rsp_valid=%0b required 1", rsp_valid);
    end
    collect("add_f0_10");
    send("sub_05_07", 2'd1, 8'h05, 8'h07, 1'b1);
    collect("sub_05_07");
    send("cmp_33_33", 2'd2, 8'h33, 8'h33, 1'b1);
    collect("cmp_33_33");
    send("inc_ff", 2'd3, 8'hFF, 8'h55, 1'b1);
    collect("inc_ff");
    send("inc_01", 2'd3, 8'h01, 8'hFF, 1'b1);
    collect("inc_01");
    send("cmp_10_20", 2'd2, 8'h10, 8'h20, 1'b1);
    collect("cmp_10_20");
  endtask

  task automatic test_back_to_back();
    send("add_3_4", 2'd0, 8'h03, 8'h04, 1'b1);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_a     = 8'hAA;
    req_b     = 8'h01;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h07 || req_ready !== 1'b0 ||
          c_flag !== 1'b0 || z_flag !== 1'b0) begin
        bad++;
        $display("FAIL hold[%0d]: vld=%0b data=%h rdy=%0b c=%0b z=%0b required 1 07 0 0 0", i,
                 rsp_valid, rsp_data, req_ready, c_flag, z_flag);
      end
      @(negedge clk);
    end
    collect("add_3_4_held");
    total++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL no_bypass: busy=%0b req_ready=%0b required 0 1", busy, req_ready);
    end
    @(posedge clk);
    sb_q.push_back(model(2'd1, 8'hAA, 8'h01));
    #1;
    req_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL next_accept: busy=%0b required 1", busy);
    end
    collect("sub_aa_01");
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    send("sub_9_9", 2'd1, 8'h09, 8'h09, 1'b0);
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || c_flag !== 1'b0 || z_flag !== 1'b0 ||
        rsp_data !== '0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset: busy=%0b vld=%0b c=%0b z=%0b data=%h rdy=%0b required 0 0 0 0 00 1",
               busy, rsp_valid, c_flag, z_flag, rsp_data, req_ready);
    end
    @(negedge clk);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    total++;
    if (seen) begin
      bad++;
      $display("FAIL abandoned_rsp: rsp_valid seen=1 required 0");
    end
    rst       = 1'b1;
    #1;
    req_valid = 1'b1;
    req_op    = 2'd0;
    req_a     = 8'h01;
    req_b     = 8'h01;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    sb_q.push_back(model(2'd0, 8'h01, 8'h01));
    #1;
    req_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL first_edge_accept: busy=%0b required 1", busy);
    end
    collect("add_after_reset");
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    rst       = 1'b0;
    test_reset();
    test_ops();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
